apb_master_bridge: RTL
======================

// Module: apb_master_bridge
// PURPOSE
//  APB initiator: turns single read/write commands from a local requester (test
//  sequencer / host-side controller) into APB transfers toward POLI's APB slave.
//  Runs one transfer at a time: IDLE -> SETUP -> ACCESS, then holds a response until taken.
//  Adds wait-state handling, PSLVERR propagation and a bus-hang timeout.
// PARAMETERS
//  ADDR_WIDTH   32  PADDR / cmd_addr width
//  DATA_WIDTH   32  PWDATA/PRDATA width (equals WORD_SIZE)
//  TIMEOUT      16  max ACCESS cycles waiting for PREADY; 0 = no timeout
// PORTS
//  CLK         in   1           clock, all logic on posedge
//  nRST        in   1           reset, synchronous, active-low
//  cmd_valid   in   1           command offered
//  cmd_ready   out  1           command accepted when valid&ready
//  cmd_write   in   1           1 = write, 0 = read
//  cmd_addr    in   ADDR_WIDTH  target address
//  cmd_wdata   in   DATA_WIDTH  write data (ignored on reads)
//  rsp_valid   out  1           response available
//  rsp_ready   in   1           response consumed when valid&ready
//  rsp_rdata   out  DATA_WIDTH  read data; 0 for writes and on timeout
//  rsp_error   out  1           PSLVERR seen or timeout
//  PSEL        out  1           APB select
//  PENABLE     out  1           APB enable
//  PWRITE      out  1           APB direction
//  PADDR       out  ADDR_WIDTH  APB address
//  PWDATA      out  DATA_WIDTH  APB write data
//  PRDATA      in   DATA_WIDTH  APB read data
//  PREADY      in   1           APB ready / wait-state
//  PSLVERR     in   1           APB slave error
// BEHAVIOUR
//  Reset (nRST=0 at posedge): state=IDLE, all outputs 0 except cmd_ready=1; timeout count=0.
//  States / outputs (registered):
//   IDLE:   cmd_ready=1, PSEL=0, PENABLE=0. cmd_valid=1 -> latch PADDR/PWDATA/PWRITE -> SETUP.
//   SETUP:  PSEL=1, PENABLE=0, one cycle -> ACCESS.
//   ACCESS: PSEL=1, PENABLE=1. PREADY=1 -> capture rsp_rdata (PRDATA if read, else 0),
//           rsp_error=PSLVERR -> RESP. Else count++; count==TIMEOUT (TIMEOUT>0) ->
//           rsp_rdata=0, rsp_error=1 -> RESP.
//   RESP:   PSEL=0, PENABLE=0, rsp_valid=1; rsp_ready=1 -> IDLE (rsp_valid=0 next cycle).
//  cmd_ready=0 in SETUP/ACCESS/RESP; cmd_valid ignored there (no queueing).
//  PADDR/PWDATA/PWRITE change only on accept; stable SETUP..end of ACCESS; hold after.
//  Min latency: accept edge -> rsp_valid=1 three edges later (PREADY high in first ACCESS).
//  Timeout count clears on entry to SETUP; ACCESS lasts at most TIMEOUT cycles.
//  PSLVERR sampled only in the cycle PREADY=1; otherwise ignored.
//  rsp_rdata/rsp_error stable while rsp_valid=1 regardless of APB inputs.
//  Reset mid-transfer: next edge PSEL=PENABLE=0, no response issued, back to IDLE.
//  Accept in same cycle rsp handshake completes: not possible (RESP->IDLE first).
// TESTING
//  Write 0x0000_0004<=0xDEADBEEF, PREADY=1 -> PSEL 2 cycles, PENABLE 1, rsp_valid 3 edges after accept, rsp_error=0, rsp_rdata=0.
//  Read 0x0000_0008, PREADY low 3 ACCESS cycles then high with PRDATA=0x1234_5678 -> PENABLE 4 cycles, rsp_rdata=0x1234_5678.
//  Write with PREADY=1, PSLVERR=1 -> rsp_error=1; PSLVERR=1 while PREADY=0 alone -> no effect.
//  Read, PREADY stuck 0, TIMEOUT=16 -> PSEL/PENABLE drop after 16 ACCESS cycles, rsp_error=1, rsp_rdata=0.
//  rsp_ready low 5 cycles with new cmd_valid -> rsp_valid/data held, cmd_ready=0, no new PSEL.
//  nRST=0 during ACCESS -> next edge PSEL=PENABLE=rsp_valid=0, cmd_ready=1; next command runs normally.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Requester command/response handshake plus APB bus wires for apb_master_bridge.
// The master modport is the bridge's view; slave is the requester + APB slave side.
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  rsp_ready, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output rsp_ready, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator: one command at a time, IDLE -> SETUP -> ACCESS -> RESP.
// Wait states, PSLVERR propagation and an ACCESS-phase hang timeout.
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic CLK,
  input  logic nRST,
  apb_master_bridge_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          rdata_d = pwrite_q ? '0 : bus.PRDATA;
          err_d   = bus.PSLVERR;
          state_d = RESP;
        end else if (TIMEOUT > 0 && cnt_q == LAST) begin
          // Slave never answered: report an error with no data
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = err_q;
  assign bus.PSEL      = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.PENABLE   = (state_q == ACCESS);
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;

endmodule
